// File: rtl/trisc_ctrl_pkg.sv
// trisc_ctrl_pkg
//   Shared definitions for the TRISC control sequencer:
//   - state_t : 4-bit sequencer state encoding (visible on the debug port)
//   - opc_t   : compact opcode latched in DECODE for the execute states
//   - OP_*    : bit positions of each instruction in the one-hot dec vector
//   - DEFAULT_TIMEOUT_CYCLES : default memory-ack timeout
package trisc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH_ADDR = 4'd0,
    S_FETCH_MEM  = 4'd1,
    S_DECODE     = 4'd2,
    S_EXEC_ADDR  = 4'd3,
    S_MEM_RD     = 4'd4,
    S_WB_LDA     = 4'd5,
    S_WB_ADD     = 4'd6,
    S_MEM_WR     = 4'd7,
    S_EXEC_1     = 4'd8,
    S_HALT       = 4'd9
  } state_t;

  typedef enum logic [2:0] {
    OPC_NONE = 3'd0,
    OPC_LDA  = 3'd1,
    OPC_STA  = 3'd2,
    OPC_ADD  = 3'd3,
    OPC_INC  = 3'd4,
    OPC_CLR  = 3'd5,
    OPC_JMP  = 3'd6
  } opc_t;

  localparam int OP_LDA = 0;
  localparam int OP_STA = 1;
  localparam int OP_ADD = 2;
  localparam int OP_INC = 5;
  localparam int OP_CLR = 6;
  localparam int OP_JMP = 7;
  localparam int OP_HLT = 10;

  localparam int DEFAULT_TIMEOUT_CYCLES = 15;

endpackage

// File: rtl/trisc_control_unit.sv
// trisc_control_unit
//   Multi-cycle fetch/decode/execute sequencer for the TRISC accumulator CPU.
//   Issues all datapath strobes and handshakes with single-port memory.
//
// Parameters
//   TIMEOUT_CYCLES : unacknowledged wait cycles before an access is aborted
//                    (0 disables the timeout, range 0-255)
// Ports
//   clk, reset      : clock (rising edge), asynchronous active-high reset
//   dec[0:15]       : one-hot decoded opcode from the external decoder
//   mem_ack         : memory completes the current access this cycle
//   mem_req, mem_we : memory request and write qualifier
//   addr_sel        : MAR source (0 = PC, 1 = IR operand)
//   mar_load, ir_load, pc_inc, pc_load, mdr_load : datapath register strobes
//   acc_load, acc_add, acc_inc, acc_clr          : accumulator operations
//   halted          : high while in HALT
//   illegal_op      : pulse on unsupported / non-one-hot dec in DECODE
//   bus_err         : pulse when a memory access times out
//   instr_done      : pulse in the last cycle of each retired instruction
//   state           : current state encoding (debug)
module trisc_control_unit
  import trisc_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [0:15] dec,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        mar_load,
  output logic        ir_load,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        mdr_load,
  output logic        acc_load,
  output logic        acc_add,
  output logic        acc_inc,
  output logic        acc_clr,
  output logic        halted,
  output logic        illegal_op,
  output logic        bus_err,
  output logic        instr_done,
  output logic [3:0]  state
);

  localparam logic [7:0] TO_LIMIT  = 8'(TIMEOUT_CYCLES);
  localparam logic       TO_ENABLE = (TIMEOUT_CYCLES != 0);

  state_t     state_reg, state_next;
  opc_t       op_reg, op_next;
  logic [7:0] cnt_reg, cnt_next;

  logic dec_onehot;
  logic timed_out;

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
  assign dec_onehot = (dec != 16'd0) && ((dec & (dec - 16'd1)) == 16'd0);

  // The counter value itself marks the abort cycle, so mem_req is already
  // low when bus_err fires and a late ack in that cycle has no effect.
  assign timed_out = TO_ENABLE && (cnt_reg == TO_LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_FETCH_ADDR;
      op_reg    <= OPC_NONE;
      cnt_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    op_next    = op_reg;
    cnt_next   = cnt_reg;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 1'b0;
    mar_load   = 1'b0;
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    mdr_load   = 1'b0;
    acc_load   = 1'b0;
    acc_add    = 1'b0;
    acc_inc    = 1'b0;
    acc_clr    = 1'b0;
    halted     = 1'b0;
    illegal_op = 1'b0;
    bus_err    = 1'b0;
    instr_done = 1'b0;

    case (state_reg)
      S_FETCH_ADDR: begin
        mar_load   = 1'b1;
        cnt_next   = 8'd0;
        state_next = S_FETCH_MEM;
      end

      S_FETCH_MEM: begin
        if (timed_out) begin
          bus_err    = 1'b1;
          state_next = S_FETCH_ADDR;
        end else begin
          mem_req = 1'b1;
          if (mem_ack) begin
            ir_load    = 1'b1;
            pc_inc     = 1'b1;
            state_next = S_DECODE;
          end else begin
            cnt_next = cnt_reg + 8'd1;
          end
        end
      end

      S_DECODE: begin
        if (!dec_onehot) begin
          illegal_op = 1'b1;
          instr_done = 1'b1;
          state_next = S_FETCH_ADDR;
        end else if (dec[OP_LDA]) begin
          op_next    = OPC_LDA;
          state_next = S_EXEC_ADDR;
        end else if (dec[OP_STA]) begin
          op_next    = OPC_STA;
          state_next = S_EXEC_ADDR;
        end else if (dec[OP_ADD]) begin
          op_next    = OPC_ADD;
          state_next = S_EXEC_ADDR;
        end else if (dec[OP_INC]) begin
          op_next    = OPC_INC;
          state_next = S_EXEC_1;
        end else if (dec[OP_CLR]) begin
          op_next    = OPC_CLR;
          state_next = S_EXEC_1;
        end else if (dec[OP_JMP]) begin
          op_next    = OPC_JMP;
          state_next = S_EXEC_1;
        end else if (dec[OP_HLT]) begin
          // HLT retires here; HALT itself keeps every strobe low.
          instr_done = 1'b1;
          state_next = S_HALT;
        end else begin
          illegal_op = 1'b1;
          instr_done = 1'b1;
          state_next = S_FETCH_ADDR;
        end
      end

      S_EXEC_ADDR: begin
        mar_load   = 1'b1;
        addr_sel   = 1'b1;
        cnt_next   = 8'd0;
        state_next = (op_reg == OPC_STA) ? S_MEM_WR : S_MEM_RD;
      end

      S_MEM_RD: begin
        if (timed_out) begin
          bus_err    = 1'b1;
          state_next = S_FETCH_ADDR;
        end else begin
          mem_req = 1'b1;
          if (mem_ack) begin
            mdr_load   = 1'b1;
            state_next = (op_reg == OPC_ADD) ? S_WB_ADD : S_WB_LDA;
          end else begin
            cnt_next = cnt_reg + 8'd1;
          end
        end
      end

      S_WB_LDA: begin
        acc_load   = 1'b1;
        instr_done = 1'b1;
        state_next = S_FETCH_ADDR;
      end

      S_WB_ADD: begin
        acc_add    = 1'b1;
        instr_done = 1'b1;
        state_next = S_FETCH_ADDR;
      end

      S_MEM_WR: begin
        if (timed_out) begin
          bus_err    = 1'b1;
          state_next = S_FETCH_ADDR;
        end else begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          if (mem_ack) begin
            instr_done = 1'b1;
            state_next = S_FETCH_ADDR;
          end else begin
            cnt_next = cnt_reg + 8'd1;
          end
        end
      end

      S_EXEC_1: begin
        acc_inc    = (op_reg == OPC_INC);
        acc_clr    = (op_reg == OPC_CLR);
        pc_load    = (op_reg == OPC_JMP);
        instr_done = 1'b1;
        state_next = S_FETCH_ADDR;
      end

      S_HALT: begin
        halted = 1'b1;
      end

      default: begin
        state_next = S_FETCH_ADDR;
      end
    endcase

    // Reset forces every output low immediately, even mid-access, without
    // waiting for the state register to settle.
    if (reset) begin
      {mem_req, mem_we, addr_sel, mar_load, ir_load, pc_inc, pc_load,
       mdr_load, acc_load, acc_add, acc_inc, acc_clr, halted, illegal_op,
       bus_err, instr_done} = 16'd0;
    end
  end

  assign state = reset ? 4'd0 : state_reg;

endmodule
